// File: rtl/axilite_regfile_slave.sv
// AXI4-Lite slave with NUM_REGS byte-strobed 32-bit registers.
// Independent AW/W holding slots, registered B/R responses, SLVERR out of range.
module axilite_regfile_slave #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                r_aw_full;
    logic [IW-1:0]       r_aw_idx;
    logic                r_w_full;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic                w_aw_in_range;
    logic                w_ar_in_range;
    logic [IW-1:0]       w_ar_idx;
    logic [31:0]         w_rd_data;
    logic [NUM_REGS-1:0] w_wr_onehot;
    logic                w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = !reset && !r_aw_full && !r_bvalid;
    assign s_axi_wready  = !reset && !r_w_full && !r_bvalid;
    assign s_axi_arready = !reset && !r_rvalid;

    assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
    assign w_commit = r_aw_full && r_w_full && !r_bvalid;

    assign w_ar_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
    assign w_aw_in_range = 32'(r_aw_idx) < 32'(NUM_REGS);
    assign w_ar_in_range = 32'(w_ar_idx) < 32'(NUM_REGS);

    always_comb begin
        w_wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_commit && 32'(r_aw_idx) == 32'(i)) begin
                w_wr_onehot[i] = 1'b1;
            end
        end
    end

    // Out-of-range indices match no register and fall through as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_ar_idx) == 32'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_full  <= 1'b0;
                r_w_full   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
                r_wr_pulse <= w_wr_onehot;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                r_regs[i] <= '0;
            end else if (w_wr_onehot[i]) begin
                for (int k = 0; k < 4; k++) begin
                    if (r_wstrb[k]) begin
                        r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // Reads sample r_regs before any same-edge commit lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = r_regs[g];
    end

    assign reg_wr_pulse = r_wr_pulse;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_axilite_regfile_slave.sv
// Randomized bench for axilite_regfile_slave against an array model.
// Uses NUM_REGS=3 so index 3 (addr 0xC..0xF) is out of range.
module tb_axilite_regfile_slave;

    localparam int NR = 3;
    localparam int AW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   s_axi_awaddr;
    logic [2:0]      s_axi_awprot;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic [2:0]      s_axi_arprot;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]   reg_wr_pulse;

    axilite_regfile_slave #(.NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [NR];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] v = '0;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic send_aw(input logic [AW-1:0] a, input int pre);
        int n = 0;
        repeat (pre) tick();
        s_axi_awaddr  = a;
        s_axi_awprot  = 3'($urandom_range(0, 7));
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("aw_timeout", 1, 0);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input int pre);
        int n = 0;
        repeat (pre) tick();
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("w_timeout", 1, 0);
        tick();
        s_axi_wvalid = 1'b0;
    endtask

    // Called right after the later of the AW/W handshakes.
    task automatic finish_b(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bdelay);
        int idx = int'(a[AW-1:2]);
        logic [1:0] er = (idx < NR) ? 2'b00 : 2'b10;
        logic [NR-1:0] ep = (idx < NR) ? NR'(1 << idx) : '0;
        chk("b_early", s_axi_bvalid, 0);
        tick();
        if (idx < NR)
            for (int k = 0; k < 4; k++)
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        chk("b_valid", s_axi_bvalid, 1);
        chk("b_resp", s_axi_bresp, er);
        chk("wr_pulse", reg_wr_pulse, ep);
        chk("reg_out", reg_out, model_flat());
        repeat (bdelay) begin
            tick();
            chk("b_hold", {s_axi_bvalid, s_axi_bresp,
                           s_axi_awready, s_axi_wready},
                {1'b1, er, 1'b0, 1'b0});
            chk("pulse_off", reg_wr_pulse, 0);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("b_clear", s_axi_bvalid, 0);
        chk("pulse_off", reg_wr_pulse, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_pre,
                            input int w_pre, input int bdelay);
        fork
            send_aw(a, aw_pre);
            send_w(d, s, w_pre);
        join
        finish_b(a, d, s, bdelay);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdelay);
        int n = 0;
        int idx = int'(a[AW-1:2]);
        logic [31:0] ed = (idx < NR) ? model[idx] : 32'h0;
        logic [1:0] er = (idx < NR) ? 2'b00 : 2'b10;
        s_axi_araddr  = a;
        s_axi_arprot  = 3'($urandom_range(0, 7));
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("ar_timeout", 1, 0);
        tick();
        s_axi_arvalid = 1'b0;
        chk("r_valid", s_axi_rvalid, 1);
        chk("r_data", s_axi_rdata, ed);
        chk("r_resp", s_axi_rresp, er);
        repeat (rdelay) begin
            tick();
            chk("r_hold", {s_axi_rvalid, s_axi_rdata, s_axi_rresp,
                           s_axi_arready}, {1'b1, ed, er, 1'b0});
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        chk("r_clear", s_axi_rvalid, 0);
    endtask

    initial begin
        logic [31:0] old;
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) tick();
        chk("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        chk("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 0);
        chk("rst_regs", reg_out, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        reset = 1'b0;
        #1;
        chk("idle_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        for (int i = 0; i < 4; i++)
            do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            do_read(AW'(4 * i), 0);

        send_w(32'hA5A5A5A5, 4'hF, 0);
        repeat (3) begin
            chk("wfirst_wready", s_axi_wready, 0);
            chk("wfirst_awready", s_axi_awready, 1);
            chk("wfirst_nob", s_axi_bvalid, 0);
            tick();
        end
        send_aw(4'h4, 0);
        finish_b(4'h4, 32'hA5A5A5A5, 4'hF, 0);
        do_read(4'h4, 0);

        do_write(4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(4'h8, 32'h12345678, 4'b0101, 0, 0, 0);
        chk("strb_model", model[2], 32'hFF34FF78);
        do_read(4'h8, 2);
        do_write(4'h0, 32'hDEADBEEF, 4'h0, 0, 0, 0);
        do_write(4'hC, 32'h55555555, 4'hF, 0, 0, 10);
        do_read(4'hC, 4);

        old = model[2];
        fork
            send_aw(4'h8, 0);
            send_w(32'hCAFEF00D, 4'hF, 0);
        join
        s_axi_araddr  = 4'h8;
        s_axi_arvalid = 1'b1;
        chk("col_arready", s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
        model[2] = 32'hCAFEF00D;
        chk("col_rdata", s_axi_rdata, old);
        chk("col_bvalid", s_axi_bvalid, 1);
        chk("col_regs", reg_out, model_flat());
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        chk("col_clear", {s_axi_bvalid, s_axi_rvalid}, 0);

        for (int it = 0; it < 120; it++) begin
            logic [AW-1:0] a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        fork
            send_aw(4'h0, 0);
            send_w(32'h0BADF00D, 4'hF, 0);
        join
        tick();
        chk("pre_rst_b", s_axi_bvalid, 1);
        reset = 1'b1;
        #1;
        chk("rst_force_rdy", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        tick();
        for (int i = 0; i < NR; i++) model[i] = '0;
        chk("mid_rst_b", s_axi_bvalid, 0);
        chk("mid_rst_regs", reg_out, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", {s_axi_awready, s_axi_wready}, 2'b11);
        do_read(4'h4, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
